// File: rtl/loopback_pkg.sv
// Shared definitions for the loopback tester: FSM encoding, LFSR constants
// and the index sentinels reported through first_err_idx.
package loopback_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RST_DUT = 3'd1;
    localparam state_t ST_RUN     = 3'd2;
    localparam state_t ST_DRAIN   = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [15:0] IDX_NONE  = 16'hFFFF;
    localparam logic [15:0] IDX_RST   = 16'hFFFE;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/loopback_lfsr.sv
// 16-bit Fibonacci LFSR producing the stimulus pattern; reload restarts it
// from the fixed seed so every run applies the same vector sequence.
module loopback_lfsr
    import loopback_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [15:0] state
);

    logic [15:0] lfsr_r;

    // Seed reload takes priority over stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
        end else if (load) begin
            lfsr_r <= LFSR_SEED;
        end else if (step) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign state = lfsr_r;

endmodule

// File: rtl/loopback_tester.sv
// Loopback tester: resets the external stage, drives LFSR stimulus into it
// and checks the returned parity bits through a one-stage check pipeline.
module loopback_tester
    import loopback_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       num_vectors,
    output logic [IN_W-1:0]   stim,
    output logic              dut_rst_n,
    input  logic [OUT_W-1:0]  resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [15:0]       first_err_idx
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic                phase_r;
    logic [15:0]         nvec_r;
    logic [15:0]         vec_idx_r;
    logic                start_acc_s;
    logic                lfsr_step_s;
    logic [15:0]         lfsr_state_s;
    logic [IN_W-1:0]     stim_r;
    logic                dut_rst_n_r;
    logic                busy_r;
    logic                done_r;
    logic                pass_r;
    logic                chk_valid_r;
    logic [OUT_W-1:1]    chk_resp_r;
    logic [OUT_W-1:1]    chk_exp_r;
    logic [15:0]         chk_idx_r;
    logic                mismatch_s;
    logic [15:0]         err_count_r;
    logic [15:0]         first_err_r;
    logic                unused_s;

    // Bit j of the response is the reset level XORed with stim[0 .. IN_W-OUT_W+j].
    function automatic logic [OUT_W-1:1] exp_resp(input logic [IN_W-1:0] s,
                                                  input logic            rn);
        logic [OUT_W-1:1] e;
        logic             p;
        e = {(OUT_W-1){1'b0}};
        for (int j = 1; j < OUT_W; j++) begin
            p = rn;
            for (int i = 0; i < IN_W; i++) begin
                if (i <= IN_W - OUT_W + j) begin
                    p = p ^ s[i];
                end else begin
                    p = p;
                end
            end
            e[j] = p;
        end
        return e;
    endfunction

    assign start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign lfsr_step_s = (state_nxt_s == ST_RUN);
    assign mismatch_s  = chk_valid_r && (chk_resp_r != chk_exp_r);
    // Bit 0 is the clock echo and upper LFSR bits exceed the stimulus width.
    assign unused_s    = ^{resp[0], lfsr_state_s};

    loopback_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (start_acc_s),
        .step  (lfsr_step_s),
        .state (lfsr_state_s)
    );

    // Next-state logic; phase_r marks the second cycle of the two-cycle states.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s = ST_RST_DUT;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RST_DUT: begin
                if (!phase_r) begin
                    state_nxt_s = ST_RST_DUT;
                end else if (nvec_r == 16'd0) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (vec_idx_r == nvec_r - 16'd1) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (phase_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State and dwell-phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            phase_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            phase_r <= (state_nxt_s == state_r);
        end
    end

    // Run length capture and vector index.
    always_ff @(posedge clk) begin
        if (rst) begin
            nvec_r    <= 16'd0;
            vec_idx_r <= 16'd0;
        end else if (start_acc_s) begin
            nvec_r    <= num_vectors;
            vec_idx_r <= 16'd0;
        end else if (state_r == ST_RUN) begin
            nvec_r    <= nvec_r;
            vec_idx_r <= vec_idx_r + 16'd1;
        end else begin
            nvec_r    <= nvec_r;
            vec_idx_r <= vec_idx_r;
        end
    end

    // Registered outputs follow the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stim_r      <= {IN_W{1'b0}};
            dut_rst_n_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            case (state_nxt_s)
                ST_RST_DUT: begin
                    stim_r      <= {IN_W{1'b0}};
                    dut_rst_n_r <= 1'b0;
                end
                ST_RUN: begin
                    stim_r      <= lfsr_state_s[IN_W-1:0];
                    dut_rst_n_r <= 1'b1;
                end
                default: begin
                    stim_r      <= stim_r;
                    dut_rst_n_r <= 1'b1;
                end
            endcase
            busy_r <= (state_nxt_s == ST_RST_DUT) || (state_nxt_s == ST_RUN) ||
                      (state_nxt_s == ST_DRAIN);
            done_r <= (state_nxt_s == ST_DONE);
            // The count is final by the second DRAIN cycle, so it is safe to sample here.
            pass_r <= (state_nxt_s == ST_DONE) && (err_count_r == 16'd0);
        end
    end

    // Check stage: capture the response, its expected value and the vector index.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_valid_r <= 1'b0;
            chk_resp_r  <= {(OUT_W-1){1'b0}};
            chk_exp_r   <= {(OUT_W-1){1'b0}};
            chk_idx_r   <= IDX_NONE;
        end else begin
            chk_valid_r <= (state_r == ST_RST_DUT) || (state_r == ST_RUN);
            chk_resp_r  <= resp[OUT_W-1:1];
            chk_exp_r   <= exp_resp(stim_r, dut_rst_n_r);
            chk_idx_r   <= (state_r == ST_RST_DUT) ? IDX_RST : vec_idx_r;
        end
    end

    // Error accounting: saturating count, first index latched once.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= 16'd0;
            first_err_r <= IDX_NONE;
        end else if (start_acc_s) begin
            err_count_r <= 16'd0;
            first_err_r <= IDX_NONE;
        end else if (mismatch_s) begin
            if (err_count_r != CNT_MAX) begin
                err_count_r <= err_count_r + 16'd1;
            end else begin
                err_count_r <= err_count_r;
            end
            if (first_err_r == IDX_NONE) begin
                first_err_r <= chk_idx_r;
            end else begin
                first_err_r <= first_err_r;
            end
        end else begin
            err_count_r <= err_count_r;
            first_err_r <= first_err_r;
        end
    end

    assign stim          = stim_r;
    assign dut_rst_n     = dut_rst_n_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_count_r;
    assign first_err_idx = first_err_r;

endmodule

// File: tb/tb_loopback_tester.sv
// Randomised scoreboard bench for loopback_tester with a behavioural loopback
// stage that can inject several fault patterns.
module tb_loopback_tester;

    localparam int IN_W  = 8;
    localparam int OUT_W = 4;

    typedef struct {
        logic [15:0] err;
        logic [15:0] first;
        logic        pass;
        int          done_cyc;
    } result_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [15:0]       num_vectors;
    logic [IN_W-1:0]   stim;
    logic              dut_rst_n;
    logic [OUT_W-1:0]  resp;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;
    logic [15:0]       first_err_idx;

    logic [OUT_W-1:1]  resp_hi;
    int                mode;
    int                run_cycles;
    int                cyc;
    int                n_checks;
    int                n_fail;
    logic              done_q;
    result_t           res_q[$];
    logic [IN_W-1:0]   stim_q[$];
    result_t           r_mon;

    loopback_tester #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_vectors   (num_vectors),
        .stim          (stim),
        .dut_rst_n     (dut_rst_n),
        .resp          (resp),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Ideal stage: bit j is reset level XOR parity of the low (IN_W-OUT_W+j+1) stim bits.
    function automatic logic [OUT_W-1:1] ideal_hi(input logic [IN_W-1:0] s, input logic rn);
        logic [OUT_W-1:1] h;
        int sv;
        int span;
        h  = '0;
        sv = int'(s);
        for (int j = 1; j < OUT_W; j++) begin
            span = IN_W - OUT_W + j + 1;
            h[j] = rn ^ (($countones(sv & ((1 << span) - 1)) % 2) == 1);
        end
        return h;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int model_errs(input int m, input int n);
        case (m)
            1:       return (n > 5) ? n - 5 : 0;
            2:       return 2;
            3:       return n + 2;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] model_first(input int m, input int n);
        case (m)
            1:       return (n > 5) ? 16'd5 : 16'hFFFF;
            2, 3:    return 16'hFFFE;
            default: return 16'hFFFF;
        endcase
    endfunction

    // Cycles with the stage out of reset; during the second half of a cycle it equals vector index + 1.
    always @(negedge clk) begin
        if (!dut_rst_n) run_cycles <= 0;
        else            run_cycles <= run_cycles + 1;
    end

    // Behavioural loopback stage with fault injection selected by mode.
    always_comb begin
        resp_hi = ideal_hi(stim, dut_rst_n);
        case (mode)
            1: if (dut_rst_n && run_cycles >= 6) resp_hi[OUT_W-1] = ~resp_hi[OUT_W-1];
            2: if (!dut_rst_n) resp_hi = '1;
            3: resp_hi = ~resp_hi;
            default: ;
        endcase
    end
    assign resp = {resp_hi, clk};

    // Stimulus monitor: every applied vector must follow the seeded LFSR sequence.
    always @(negedge clk) begin
        if (!rst && busy && dut_rst_n && stim_q.size() > 0) begin
            check("stim", 32'(stim), 32'(stim_q.pop_front()));
        end
    end

    // Result monitor: compare the run summary when done rises.
    always @(negedge clk) begin
        if (done && !done_q) begin
            check("res_q_nonempty", 32'(res_q.size() != 0), 32'd1);
            if (res_q.size() != 0) begin
                r_mon = res_q.pop_front();
                check("err_count", 32'(err_count), 32'(r_mon.err));
                check("first_err_idx", 32'(first_err_idx), 32'(r_mon.first));
                check("pass", 32'(pass), 32'(r_mon.pass));
                check("done_cycle", 32'(cyc), 32'(r_mon.done_cyc));
            end
        end
        done_q <= done;
    end

    task automatic push_stim(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            stim_q.push_back(s[IN_W-1:0]);
            s = lfsr_step(s);
        end
    endtask

    task automatic run_test(input int m, input int n, input int pulses);
        result_t r;
        int      e;
        bit      got;
        @(negedge clk);
        mode    = m;
        e       = model_errs(m, n);
        r.err   = (e > 65535) ? 16'hFFFF : 16'(e);
        r.first = model_first(m, n);
        r.pass  = (e == 0);
        r.done_cyc = cyc + n + 5;
        res_q.push_back(r);
        push_stim(n);
        num_vectors = 16'(n);
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        num_vectors = 16'($urandom);
        got = 1'b0;
        for (int k = 0; k < n + 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (k < pulses * 40 && (k % 40) == 20) begin
                start       = 1'b1;
                num_vectors = 16'd5;
            end
        end
        check("done_seen", 32'(got), 32'd1);
        repeat (2) @(negedge clk);
        check("err_hold", 32'(err_count), 32'(r.err));
        check("done_hold", 32'(done), 32'd1);
        if (n == 0) check("stim_zero", 32'(stim), 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_err"}, 32'(err_count), 32'd0);
        check({tag, "_first"}, 32'(first_err_idx), 32'hFFFF);
        check({tag, "_stim"}, 32'(stim), 32'd0);
        check({tag, "_rstn"}, 32'(dut_rst_n), 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        mode        = 0;
        done_q      = 1'b0;
        rst         = 1'b1;
        start       = 1'b0;
        num_vectors = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        run_test(0, 100, 0);
        run_test(1, 20, 0);
        run_test(2, 10, 0);
        run_test(0, 0, 0);
        run_test(1, 5, 0);
        run_test(1, 6, 0);
        for (int t = 0; t < 6; t++) begin
            run_test(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), 0);
        end

        // Abort a 50-vector run around vector 10, then rerun from scratch.
        @(negedge clk);
        mode = 0;
        push_stim(50);
        num_vectors = 16'd50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        stim_q.delete();
        check_reset_state("abort");
        rst = 1'b0;
        run_test(0, 3, 0);

        run_test(3, 65535, 3);

        check("stim_q_empty", 32'(stim_q.size()), 32'd0);
        check("res_q_empty", 32'(res_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/loopback_tester.md
LOOPBACK_TESTER -- requirements
Module: loopback_tester

Interface
REQ-001 Parameter IN_W, default 8, width of stimulus vector driven into the loopback stage; legal 1..16.
REQ-002 Parameter OUT_W, default 4, width of response vector returned by the loopback stage; legal 2..IN_W+1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle pulse; begins a test run when in IDLE or DONE, ignored otherwise.
REQ-006 num_vectors  input  16  number of vectors to apply, sampled on accepted start; 0 is legal.
REQ-007 stim  output  IN_W  registered stimulus to loopback stage input.
REQ-008 dut_rst_n  output  1  registered active-low reset driven to loopback stage.
REQ-009 resp  input  OUT_W  loopback stage output; bit 0 is clock echo and is never checked.
REQ-010 busy  output  1  high in RST_DUT, RUN, DRAIN.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  valid when done; high iff err_count == 0.
REQ-013 err_count  output  16  mismatching vectors in current run, saturating at 0xFFFF.
REQ-014 first_err_idx  output  16  vector index of first mismatch; 0xFFFF if none.

Function
REQ-015 FSM states IDLE, RST_DUT, RUN, DRAIN, DONE; IDLE->RST_DUT on start; RST_DUT->RUN after 2 cycles; RUN->DRAIN after num_vectors vectors (RST_DUT->DRAIN directly if num_vectors==0); DRAIN->DONE after 2 cycles; DONE->RST_DUT on start.
REQ-016 Accepted start clears err_count to 0, first_err_idx to 0xFFFF, vector index to 0, reloads LFSR seed.
REQ-017 RST_DUT: dut_rst_n=0, stim=0; response bits OUT_W-1..1 expected 0 and checked; mismatch counts with index 0xFFFE.
REQ-018 RUN/DRAIN/DONE/IDLE: dut_rst_n=1.
REQ-019 RUN: stim = LFSR[IN_W-1:0]; LFSR advances one step per RUN cycle; vector index increments per RUN cycle.
REQ-020 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 0xACE1, shifts left with feedback into bit 0.
REQ-021 Expected response bit j (1..OUT_W-1) = dut_rst_n XOR (XOR of stim[0..IN_W-OUT_W+j]).
REQ-022 Check pipeline: at edge ending cycle k, capture resp, expected, index into stage registers; compare in cycle k+1; count updates at edge ending k+1.
REQ-023 DRAIN lasts exactly 2 cycles so last vector's comparison completes before DONE; stim held at last value during DRAIN.
REQ-024 done rises 2 cycles after last RUN cycle; pass, err_count, first_err_idx stable while DONE.
REQ-025 err_count saturates at 0xFFFF; first_err_idx written only while it is 0xFFFF.
REQ-026 start while busy is ignored; no restart, no counter clear.
REQ-027 num_vectors wider than LFSR period allowed; pattern repeats every 65535 vectors.

Reset
REQ-028 rst forces IDLE, stim=0, dut_rst_n=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0xFFFF, LFSR=seed, pipeline valid=0.
REQ-029 rst mid-run aborts immediately; no partial result survives; next start runs from scratch.

Structure
REQ-030 Shared package loopback_pkg holds state enum, LFSR seed, tap constant, sentinel values 0xFFFF/0xFFFE.
REQ-031 One sub-module loopback_lfsr (load, step, 16-bit state out); FSM, expected-parity generator and checker in loopback_tester.

Verification
REQ-032 Ideal loopback model, IN_W=8, OUT_W=4, num_vectors=100 -> done after 2+100+2 cycles, pass=1, err_count=0, first_err_idx=0xFFFF.
REQ-033 Model with resp[3] inverted from vector 5 onward, num_vectors=20 -> err_count=15, first_err_idx=5, pass=0.
REQ-034 Model ignoring dut_rst_n (resp high bits forced 1 in RST_DUT) -> err_count includes 2 reset-phase errors, first_err_idx=0xFFFE.
REQ-035 num_vectors=0 -> RST_DUT 2 cycles, DRAIN 2 cycles, done, pass=1, stim stays 0.
REQ-036 rst asserted at vector 10 of 50, then start with num_vectors=3 -> stim sequence restarts from seed 0xACE1 low bits (0xE1 first), fresh counters.
REQ-037 Constant-mismatch model, num_vectors=0xFFFF, plus start pulses while busy -> err_count saturates 0xFFFF, pulses ignored.
